// File: rtl/game_pkg.sv
// Shared types and helpers for the obstacle render engine.
package game_pkg;

  typedef enum logic [1:0] {
    StPlay,
    StHit,
    StWon
  } game_state_t;

  localparam int unsigned COORD_W_DEFAULT = 10;

  // Upper bounds used by the generic coordinate extractor.
  localparam int unsigned MAX_OBS = 16;
  localparam int unsigned MAX_W   = 16;

  localparam logic [3:0] BALL_RED   = 4'h0;
  localparam logic [3:0] BALL_GREEN = 4'hF;
  localparam logic [3:0] BALL_BLUE  = 4'h0;

  // Extract element idx of width w from a packed coordinate vector.
  function automatic logic [MAX_W-1:0] get_coord(input logic [MAX_OBS*MAX_W-1:0] vec,
                                                 input int unsigned idx,
                                                 input int unsigned w);
    logic [MAX_OBS*MAX_W-1:0] sh;
    logic [MAX_W-1:0]         mask;
    sh   = vec >> (idx * w);
    // w == MAX_W shifts the one out, so the subtraction yields all ones.
    mask = (MAX_W'(1) << w) - MAX_W'(1);
    return sh[MAX_W-1:0] & mask;
  endfunction

endpackage

// File: rtl/obs_box_test.sv
// Combinational signed box-overlap test between the ball and one obstacle.
module obs_box_test
  import game_pkg::*;
#(
  parameter int unsigned COORD_W = COORD_W_DEFAULT
) (
  input  logic               i_en,
  input  logic [COORD_W-1:0] i_ax,
  input  logic [COORD_W-1:0] i_ay,
  input  logic [COORD_W-1:0] i_bx,
  input  logic [COORD_W-1:0] i_by,
  input  logic [COORD_W-1:0] i_size,
  output logic               o_hit
);

  logic signed [COORD_W:0]   w_dx, w_dy;
  logic signed [COORD_W:0]   w_adx, w_ady;
  logic signed [COORD_W+1:0] w_adx_ext, w_ady_ext;
  logic signed [COORD_W+1:0] w_lim;

  assign w_dx      = $signed({1'b0, i_ax}) - $signed({1'b0, i_bx});
  assign w_dy      = $signed({1'b0, i_ay}) - $signed({1'b0, i_by});
  assign w_adx     = (w_dx < 0) ? -w_dx : w_dx;
  assign w_ady     = (w_dy < 0) ? -w_dy : w_dy;
  assign w_adx_ext = (COORD_W+2)'(w_adx);
  assign w_ady_ext = (COORD_W+2)'(w_ady);
  // Two radii apart: 2*size, one bit wider so it never wraps.
  assign w_lim     = $signed({1'b0, i_size, 1'b0});

  assign o_hit = i_en && (w_adx_ext < w_lim) && (w_ady_ext < w_lim);

endmodule

// File: rtl/obstacle_render_engine.sv
// Ball + obstacle renderer with per-frame collision scan and game FSM.
module obstacle_render_engine
  import game_pkg::*;
#(
  parameter int unsigned NUM_OBS         = 4,
  parameter int unsigned COORD_W         = COORD_W_DEFAULT,
  parameter int unsigned FINISH_X        = 320,
  parameter int unsigned HIT_HOLD_FRAMES = 30
) (
  input  logic                       Clk,
  input  logic                       Reset,
  input  logic                       frame_start,
  input  logic [COORD_W-1:0]         DrawX,
  input  logic [COORD_W-1:0]         DrawY,
  input  logic [COORD_W-1:0]         BallX,
  input  logic [COORD_W-1:0]         BallY,
  input  logic [COORD_W-1:0]         Ball_size,
  input  logic [NUM_OBS*COORD_W-1:0] ObsX,
  input  logic [NUM_OBS*COORD_W-1:0] ObsY,
  input  logic [NUM_OBS-1:0]         obs_enable,
  input  logic [3:0]                 foreground,
  input  logic [3:0]                 background,
  output logic [3:0]                 Red,
  output logic [3:0]                 Green,
  output logic [3:0]                 Blue,
  output logic [NUM_OBS-1:0]         collision_vec,
  output logic                       collision,
  output logic                       reset_player,
  output logic                       finish_line_reached,
  output logic                       scan_busy
);

  localparam int unsigned IDX_W = (NUM_OBS > 1) ? $clog2(NUM_OBS) : 1;
  localparam int unsigned SQ_W  = 2 * COORD_W + 3;
  localparam int unsigned CNT_W = (HIT_HOLD_FRAMES > 1) ? $clog2(HIT_HOLD_FRAMES + 1) : 1;
  localparam int unsigned EXT_W = MAX_OBS * MAX_W;

  logic [EXT_W-1:0] w_obsx_ext, w_obsy_ext;
  assign w_obsx_ext = EXT_W'(ObsX);
  assign w_obsy_ext = EXT_W'(ObsY);

  // ---------------------------------------------------------------- pixel pipeline
  // w_on[NUM_OBS] is the ball, lower bits are obstacles.
  logic [NUM_OBS:0] w_on;

  genvar g;
  for (g = 0; g <= NUM_OBS; g++) begin : g_circle
    logic [COORD_W-1:0]     w_cx, w_cy;
    logic signed [COORD_W:0] w_dx, w_dy;
    logic signed [SQ_W-1:0]  w_d2, w_r2;
    if (g == NUM_OBS) begin : g_ball
      assign w_cx = BallX;
      assign w_cy = BallY;
    end else begin : g_obs
      assign w_cx = COORD_W'(get_coord(w_obsx_ext, g, COORD_W));
      assign w_cy = COORD_W'(get_coord(w_obsy_ext, g, COORD_W));
    end
    assign w_dx   = $signed({1'b0, DrawX}) - $signed({1'b0, w_cx});
    assign w_dy   = $signed({1'b0, DrawY}) - $signed({1'b0, w_cy});
    assign w_d2   = SQ_W'(w_dx) * SQ_W'(w_dx) + SQ_W'(w_dy) * SQ_W'(w_dy);
    assign w_r2   = $signed(SQ_W'(Ball_size)) * $signed(SQ_W'(Ball_size));
    assign w_on[g] = (w_d2 <= w_r2);
  end

  logic               r_ball_on;
  logic [NUM_OBS-1:0] r_obs_on;
  logic [3:0]         r_red, r_green, r_blue;

  // S1: register per-object on-bits; disabled obstacles never light.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_ball_on <= 1'b0;
      r_obs_on  <= '0;
    end else begin
      r_ball_on <= w_on[NUM_OBS];
      r_obs_on  <= w_on[NUM_OBS-1:0] & obs_enable;
    end
  end

  // S2: colour priority ball > any obstacle > background.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_red   <= '0;
      r_green <= '0;
      r_blue  <= '0;
    end else if (r_ball_on) begin
      r_red   <= BALL_RED;
      r_green <= BALL_GREEN;
      r_blue  <= BALL_BLUE;
    end else if (|r_obs_on) begin
      r_red   <= foreground;
      r_green <= foreground >> 1;
      r_blue  <= foreground >> 1;
    end else begin
      r_red   <= background;
      r_green <= background;
      r_blue  <= background;
    end
  end

  assign Red   = r_red;
  assign Green = r_green;
  assign Blue  = r_blue;

  // ---------------------------------------------------------------- collision scan
  logic               r_busy;
  logic [IDX_W-1:0]   r_idx;
  logic [NUM_OBS-1:0] r_shadow, r_coll_vec;
  logic [COORD_W-1:0] r_bx, r_by, r_bs;
  logic [COORD_W-1:0] w_sx, w_sy;
  logic               w_box_hit, w_last, w_commit;
  logic [NUM_OBS-1:0] w_new_vec;

  assign w_sx = COORD_W'(get_coord(w_obsx_ext, 32'(r_idx), COORD_W));
  assign w_sy = COORD_W'(get_coord(w_obsy_ext, 32'(r_idx), COORD_W));

  obs_box_test #(
    .COORD_W(COORD_W)
  ) u_box (
    .i_en   (obs_enable[r_idx]),
    .i_ax   (r_bx),
    .i_ay   (r_by),
    .i_bx   (w_sx),
    .i_by   (w_sy),
    .i_size (r_bs),
    .o_hit  (w_box_hit)
  );

  assign w_last   = (r_idx == IDX_W'(NUM_OBS - 1));
  // A frame_start on the final cycle aborts the scan instead of committing it.
  assign w_commit = r_busy && w_last && !frame_start;

  // Shadow vector with the current index's result merged in.
  always_comb begin
    w_new_vec        = r_shadow;
    w_new_vec[r_idx] = w_box_hit;
  end

  // Scan sequencer: start/restart on frame_start, commit after the last index.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_busy     <= 1'b0;
      r_idx      <= '0;
      r_shadow   <= '0;
      r_coll_vec <= '0;
      r_bx       <= '0;
      r_by       <= '0;
      r_bs       <= '0;
    end else if (frame_start) begin
      r_busy   <= 1'b1;
      r_idx    <= '0;
      r_shadow <= '0;
      r_bx     <= BallX;
      r_by     <= BallY;
      r_bs     <= Ball_size;
    end else if (r_busy) begin
      r_shadow <= w_new_vec;
      if (w_last) begin
        r_busy     <= 1'b0;
        r_coll_vec <= w_new_vec;
      end else begin
        r_idx <= r_idx + 1'b1;
      end
    end
  end

  assign scan_busy     = r_busy;
  assign collision_vec = r_coll_vec;
  assign collision     = |r_coll_vec;

  // ---------------------------------------------------------------- game FSM
  game_state_t      r_state, w_state_d;
  logic [CNT_W-1:0] r_cnt, w_cnt_d;
  logic             r_pulse, w_pulse_d;

  // FSM state, hold-off counter and registered reset_player pulse.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      r_state <= StPlay;
      r_cnt   <= '0;
      r_pulse <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_pulse <= w_pulse_d;
    end
  end

  // Next-state: hits win over finish; HIT counts frames before returning to PLAY.
  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    w_pulse_d = 1'b0;
    case (r_state)
      StPlay: begin
        if (w_commit) begin
          if (|w_new_vec) begin
            w_state_d = StHit;
            w_pulse_d = 1'b1;
            w_cnt_d   = '0;
          end else if (r_bx >= COORD_W'(FINISH_X)) begin
            w_state_d = StWon;
          end
        end
      end
      StHit: begin
        if (frame_start) begin
          if (r_cnt == CNT_W'(HIT_HOLD_FRAMES - 1)) begin
            w_state_d = StPlay;
            w_cnt_d   = '0;
          end else begin
            w_cnt_d = r_cnt + 1'b1;
          end
        end
      end
      StWon: begin
        w_state_d = StWon;
      end
      default: begin
        w_state_d = StPlay;
      end
    endcase
  end

  assign reset_player        = r_pulse;
  assign finish_line_reached = (r_state == StWon);

endmodule
